ps2_host_tx: RTL

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the shared open-collector PS2C/PS2D lines and reports device acknowledge. It sits beside the keyboard scan-code receiver on the same pins and the same 25 MHz clock. It drives the lines only through active-high pull-low enables; top level converts these to tri-state buffers. All logic is synchronous to clk25; the PS/2 clock is never used as a clock.

---
 rtl/ps2_host_tx_if.sv | 9 +
 rtl/ps2_host_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command-byte request handshake for the PS/2 host transmitter
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter with device ACK check
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic         clk25,
    input  logic         clr_n,
    ps2_host_tx_if.slave tx,
    input  logic         PS2C,
    input  logic         PS2D,
    output logic         ps2c_oe,
    output logic         ps2d_oe,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE} state_t;

    state_t        state;
    logic [7:0]    c_sh, d_sh;
    logic          c_f, d_f, c_prev;
    logic [7:0]    data_q;
    logic          parity_q;
    logic          ack_bit;
    logic          tx_ready_q;
    logic [3:0]    bit_idx;
    logic [CW-1:0] cnt;
    logic          fall;
    logic [3:0]    next_idx;

    assign fall        = c_prev & ~c_f;
    assign next_idx    = bit_idx + 4'd1;
    assign tx.tx_ready = tx_ready_q;

    // Shift filters double as synchronisers; the level only moves on 8 agreeing samples.
    always_ff @(posedge clk25 or negedge clr_n) begin
        if (!clr_n) begin
            c_sh   <= 8'hFF;
            d_sh   <= 8'hFF;
            c_f    <= 1'b1;
            d_f    <= 1'b1;
            c_prev <= 1'b1;
        end else begin
            c_sh   <= {c_sh[6:0], PS2C};
            d_sh   <= {d_sh[6:0], PS2D};
            c_prev <= c_f;
            if (c_sh == 8'h00)      c_f <= 1'b0;
            else if (c_sh == 8'hFF) c_f <= 1'b1;
            if (d_sh == 8'h00)      d_f <= 1'b0;
            else if (d_sh == 8'hFF) d_f <= 1'b1;
        end
    end

    always_ff @(posedge clk25 or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            ps2c_oe    <= 1'b0;
            ps2d_oe    <= 1'b0;
            tx_ready_q <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            bit_idx    <= 4'd0;
            cnt        <= '0;
            data_q     <= 8'h00;
            parity_q   <= 1'b0;
            ack_bit    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // done/err cycle lands here with tx_ready still low, so ready returns one cycle later
                    ps2c_oe    <= 1'b0;
                    ps2d_oe    <= 1'b0;
                    tx_ready_q <= 1'b1;
                    busy       <= 1'b0;
                    bit_idx    <= 4'd0;
                    cnt        <= '0;
                    if (tx.tx_valid && tx_ready_q) begin
                        data_q     <= tx.tx_data;
                        parity_q   <= ~^tx.tx_data;
                        tx_ready_q <= 1'b0;
                        busy       <= 1'b1;
                        ps2c_oe    <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt     <= '0;
                        ps2d_oe <= 1'b1;
                        state   <= START;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                START: begin
                    ps2c_oe <= 1'b0;
                    cnt     <= '0;
                    bit_idx <= 4'd0;
                    state   <= SEND;
                end
                SEND: begin
                    if (fall) begin
                        cnt     <= '0;
                        bit_idx <= next_idx;
                        if (next_idx <= 4'd8) begin
                            ps2d_oe <= ~data_q[3'(next_idx - 4'd1)];
                        end else if (next_idx == 4'd9) begin
                            ps2d_oe <= ~parity_q;
                        end else if (next_idx == 4'd10) begin
                            ps2d_oe <= 1'b0;
                        end else begin
                            ack_bit <= d_f;
                            ps2d_oe <= 1'b0;
                            state   <= ACK;
                        end
                    end else if (cnt == TO_LAST) begin
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b0;
                        err     <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ACK: begin
                    cnt <= cnt + CW'(1);
                    if (ack_bit) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (c_f && d_f) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (cnt == TO_LAST) begin
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b0;
                        err     <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
